// File: rtl/fp_sign_align_pipe.sv
// Front end of an FP adder: effective operation, result sign, operand order, alignment shift, special flags.
// Two register stages (operand capture + magnitude compare, then result); 2-cycle latency, one result per cycle.
// Valid/ready backpressure: in_ready = S1 empty or S2 loading; outputs hold while out_valid & ~out_ready.
module fp_sign_align_pipe #(
    parameter int  EXP_W = 8,
    parameter int  MAN_W = 23,
    localparam int WIDTH = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             operation_select,
    input  logic             rm_down,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_r,
    output logic             swap,
    output logic             eff_sub,
    output logic [EXP_W-1:0] exp_big,
    output logic [EXP_W-1:0] exp_diff,
    output logic             out_nan,
    output logic             out_inf
);

    // Stage 1 state: captured operands plus registered magnitude compare
    logic             s1_vld;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic             s1_op;
    logic             s1_rm;
    logic             s1_gt;
    logic             s1_eq;

    // Stage advance: S2 moves whenever it is empty or being drained, S1 whenever S2 can take its entry
    logic s2_load;
    logic s1_load;

    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_vld | s2_load;
    assign in_ready = s1_load;

    // Stage 1: capture operands and compare {exp,mantissa} as one unsigned magnitude
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
            s1_op  <= 1'b0;
            s1_rm  <= 1'b0;
            s1_gt  <= 1'b0;
            s1_eq  <= 1'b0;
        end else if (s1_load) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_x  <= x;
                s1_y  <= y;
                s1_op <= operation_select;
                s1_rm <= rm_down;
                s1_gt <= (x[WIDTH-2:0] > y[WIDTH-2:0]);
                s1_eq <= (x[WIDTH-2:0] == y[WIDTH-2:0]);
            end
        end
    end

    // Stage 2 combinational result derived from the stage-1 registers
    logic             sx;
    logic             sb;
    logic             sub_c;
    logic [EXP_W-1:0] ex;
    logic [EXP_W-1:0] ey;
    logic [MAN_W-1:0] mx;
    logic [MAN_W-1:0] my;
    logic [EXP_W-1:0] ex_eff;
    logic [EXP_W-1:0] ey_eff;
    logic [EXP_W-1:0] big_c;
    logic [EXP_W-1:0] diff_c;
    logic             x_nan;
    logic             y_nan;
    logic             x_inf;
    logic             y_inf;
    logic             nan_c;
    logic             inf_c;
    logic             swap_c;
    logic             sign_c;

    assign sx    = s1_x[WIDTH-1];
    assign sb    = s1_op ? s1_y[WIDTH-1] : ~s1_y[WIDTH-1];
    assign sub_c = sx ^ sb;
    assign ex    = s1_x[WIDTH-2:MAN_W];
    assign ey    = s1_y[WIDTH-2:MAN_W];
    assign mx    = s1_x[MAN_W-1:0];
    assign my    = s1_y[MAN_W-1:0];

    // Subnormals (exp 0) align as if their exponent were 1
    assign ex_eff = (ex == '0) ? EXP_W'(1) : ex;
    assign ey_eff = (ey == '0) ? EXP_W'(1) : ey;

    // Larger effective exponent and a non-negative shift amount
    always_comb begin
        big_c  = ex_eff;
        diff_c = '0;
        if (ex_eff >= ey_eff) begin
            big_c  = ex_eff;
            diff_c = ex_eff - ey_eff;
        end else begin
            big_c  = ey_eff;
            diff_c = ey_eff - ex_eff;
        end
    end

    assign x_nan = (&ex) & (mx != '0);
    assign y_nan = (&ey) & (my != '0);
    assign x_inf = (&ex) & (mx == '0);
    assign y_inf = (&ey) & (my == '0);

    // Special-case priority: NaN, then infinity, then ordinary magnitude-based sign
    always_comb begin
        nan_c  = x_nan | y_nan | (x_inf & y_inf & sub_c);
        inf_c  = ~nan_c & (x_inf | y_inf);
        swap_c = ~s1_gt & ~s1_eq;
        sign_c = 1'b0;
        if (nan_c) begin
            sign_c = 1'b0;
        end else if (inf_c) begin
            sign_c = x_inf ? sx : sb;
        end else if (s1_gt) begin
            sign_c = sx;
        end else if (s1_eq) begin
            // Exact cancellation takes its sign from the rounding direction
            sign_c = sub_c ? s1_rm : sx;
        end else begin
            sign_c = sb;
        end
    end

    // Stage 2: result registers drive the outputs directly and hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sign_r    <= 1'b0;
            swap      <= 1'b0;
            eff_sub   <= 1'b0;
            exp_big   <= '0;
            exp_diff  <= '0;
            out_nan   <= 1'b0;
            out_inf   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                sign_r   <= sign_c;
                swap     <= swap_c;
                eff_sub  <= sub_c;
                exp_big  <= big_c;
                exp_diff <= diff_c;
                out_nan  <= nan_c;
                out_inf  <= inf_c;
            end
        end
    end

endmodule

// File: doc/fp_sign_align_pipe.md
FP_SIGN_ALIGN_PIPE -- requirements
Module: fp_sign_align_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa field width; WIDTH = 1+EXP_W+MAN_W, derived, not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  x/y/operation_select/rm_down valid this cycle.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 x, y  input  WIDTH each  operands {sign, exp, mantissa}, MSB = sign.
REQ-008 operation_select  input  1  1 = x+y, 0 = x-y.
REQ-009 rm_down  input  1  1 = round toward -inf (zero-result sign rule only).
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sign_r  output  1  result sign.
REQ-013 swap  output  1  1 = |y| > |x| (y is the larger operand).
REQ-014 eff_sub  output  1  effective subtraction.
REQ-015 exp_big  output  EXP_W  larger effective exponent.
REQ-016 exp_diff  output  EXP_W  alignment shift amount.
REQ-017 out_nan, out_inf  output  1 each  special-result flags.

Function
REQ-018 Effective y sign sb SHALL be y[MSB] when operation_select=1, ~y[MSB] when 0; eff_sub = x[MSB] XOR sb.
REQ-019 Magnitude compare SHALL be unsigned on the {exp,mantissa} concatenation (WIDTH-1 bits); exponent dominates, mantissa breaks ties.
REQ-020 |x|>|y|: sign_r = x[MSB], swap=0; |x|<|y|: sign_r = sb, swap=1.
REQ-021 |x|==|y| with eff_sub=0: sign_r = x[MSB], swap=0; with eff_sub=1 (exact cancellation): sign_r = rm_down, swap=0.
REQ-022 Effective exponent SHALL be max(exp,1) (subnormals share exponent 1); exp_big = larger effective exponent, exp_diff = unsigned difference, never negative.
REQ-023 NaN (exp all-ones, mantissa != 0) on either input, or inf with inf and eff_sub=1: out_nan=1, out_inf=0, sign_r=0.
REQ-024 Otherwise any inf operand: out_inf=1, sign_r = sign of the inf operand (x[MSB] or sb); out_nan=0.
REQ-025 Pipeline SHALL be two register stages (S1 operand capture + compare, S2 result); latency exactly 2 cycles from accepted input to out_valid with out_ready held high.
REQ-026 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-027 S2 loads when S2 empty or out_ready=1; S1 loads when S1 empty or S2 loads; in_ready = S1 empty or S2 loads (combinational from out_ready).
REQ-028 Throughput one result per cycle with out_ready=1; bubbles SHALL collapse; order preserved; no drop or duplication.
REQ-029 With out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-030 Simultaneous in and out transfer on a full pipeline SHALL advance both stages in the same cycle.

Reset
REQ-031 rst=1 SHALL clear both stage valids; next cycle out_valid=0, all data outputs 0, in_ready=1.
REQ-032 rst mid-operation SHALL discard in-flight entries; input presented during rst SHALL NOT be accepted.

Verification
REQ-033 x=0x40000000, y=0x3F800000, op=1 -> after 2 cycles: sign_r=0, swap=0, eff_sub=0, exp_big=0x80, exp_diff=1.
REQ-034 x=0x3F800000, y=0x40000000, op=0 -> sign_r=1, swap=1, eff_sub=1, exp_diff=1; x=y=0x3F800000, op=0 -> sign_r=rm_down (check 0 and 1).
REQ-035 x=y=0x7F800000, op=0 -> out_nan=1, sign_r=0; x=0xFF800000, y=0x3F800000, op=1 -> out_inf=1, sign_r=1.
REQ-036 out_ready=0 for 4 cycles, in_valid=1 continuously -> exactly 2 accepted, in_ready=0 thereafter, outputs stable; release -> results in input order, one per cycle.
REQ-037 rst pulse with both stages full -> out_valid=0 next cycle, no stale result emitted after reset release.
